// File: rtl/toggle_activity_counter.sv
// rtl/toggle_activity_counter.sv - per-net toggle counter over a sampled window with indexed readout
// Optional macro TAC_TOTAL_EN adds a saturating total_count output.
module toggle_activity_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        win_len,
  input  logic [WIDTH-1:0]   probe,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat,
`ifdef TAC_TOTAL_EN
  output logic [CNT_W+IDX_W-1:0] total_count,
`endif
  output logic               done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [1:0]                  state_q, state_d;
  logic [WIDTH-1:0]            prev_q, prev_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            sat_q, sat_d;
  logic [15:0]                 rem_q, rem_d;
  logic [IDX_W-1:0]            rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0]            tog;

`ifdef TAC_TOTAL_EN
  localparam int SUM_W = CNT_W + IDX_W + 1;
  logic [CNT_W+IDX_W-1:0] total_q, total_d;
  logic [SUM_W-1:0]       sum;
`endif

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    rem_d    = rem_q;
    rd_idx_d = rd_idx_q;
    tog      = probe ^ prev_q;
`ifdef TAC_TOTAL_EN
    total_d  = total_q;
    sum      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prev_d   = probe;
          cnt_d    = '0;
          sat_d    = '0;
          rem_d    = win_len;
          rd_idx_d = '0;
`ifdef TAC_TOTAL_EN
          total_d  = '0;
`endif
          state_d  = (win_len != 16'd0) ? S_SAMPLE : S_DRAIN;
        end
      end
      S_SAMPLE: begin
        prev_d = probe;
        rem_d  = rem_q - 16'd1;
        for (int i = 0; i < WIDTH; i++) begin
          if (tog[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          // sat marks that the counter has reached all-ones, whether or not more toggles followed
          sat_d[i] = sat_q[i] | (cnt_d[i] == CNT_MAX);
        end
`ifdef TAC_TOTAL_EN
        for (int i = 0; i < WIDTH; i++) begin
          sum = sum + SUM_W'(cnt_d[i]);
        end
        total_d = sum[SUM_W-1] ? {(CNT_W+IDX_W){1'b1}} : sum[SUM_W-2:0];
`endif
        if (rem_q == 16'd1) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        rd_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= '0;
      rem_q    <= '0;
      rd_idx_q <= '0;
`ifdef TAC_TOTAL_EN
      total_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      rem_q    <= rem_d;
      rd_idx_q <= rd_idx_d;
`ifdef TAC_TOTAL_EN
      total_q  <= total_d;
`endif
    end
  end

  // Readout fields are gated by out_valid so they sit at zero outside DRAIN
  assign busy      = (state_q == S_SAMPLE) || (state_q == S_DRAIN);
  assign out_valid = (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign out_idx   = out_valid ? rd_idx_q : '0;
  assign out_count = out_valid ? cnt_q[rd_idx_q] : '0;
  assign out_sat   = out_valid ? sat_q[rd_idx_q] : 1'b0;
`ifdef TAC_TOTAL_EN
  assign total_count = total_q;
`endif

endmodule

// File: tb/tb_toggle_activity_counter.sv
// tb/tb_toggle_activity_counter.sv - randomized self-checking bench for toggle_activity_counter
module tb_toggle_activity_counter;

  localparam int W  = 4;
  localparam int CW = 4;
  localparam int IW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   win_len = '0;
  logic [W-1:0]  probe = '0;
  logic          out_ready = 1'b0;
  logic          busy, out_valid, out_sat, done;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] out_count;
`ifdef TAC_TOTAL_EN
  logic [CW+IW-1:0] total_count;
`endif

  toggle_activity_counter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .win_len(win_len),
    .probe(probe),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_count(out_count),
    .out_sat(out_sat),
`ifdef TAC_TOTAL_EN
    .total_count(total_count),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the stimulus script
  bit check_en = 1'b0;
  bit e_busy, e_valid, e_done, e_total_en;
  int e_idx, e_cnt, e_sat, e_total;

  int done_cnt = 0;
  int busy_cyc = 0;
  int n_windows = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cyc++;
    if (check_en) begin
      chk("busy", busy, e_busy);
      chk("out_valid", out_valid, e_valid);
      chk("done", done, e_done);
      if (e_valid) begin
        chk("out_idx", out_idx, e_idx);
        chk("out_count", out_count, e_cnt);
        chk("out_sat", out_sat, e_sat);
      end
`ifdef TAC_TOTAL_EN
      if (e_total_en) chk("total_count", total_count, e_total);
`endif
    end
  end

  logic [W-1:0] smp[$];
  int m_cnt[W];
  bit m_sat[W];
  int m_total;
  int obs_cnt[W];
  int obs_sat[W];
  int obs_total;

  // Count raw transitions per net across consecutive samples, then clip to the counter range
  task automatic compute_model();
    m_total = 0;
    for (int b = 0; b < W; b++) begin
      int n;
      n = 0;
      for (int i = 1; i < smp.size(); i++)
        if (smp[i][b] != smp[i-1][b]) n++;
      m_cnt[b] = (n > CMAX) ? CMAX : n;
      m_sat[b] = (n >= CMAX);
      m_total += m_cnt[b];
    end
  endtask

  task automatic expect_idle();
    e_busy = 1'b0; e_valid = 1'b0; e_done = 1'b0;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  // mode: 0 random, 1 net0 toggles, 2 net1 toggles, 3 all nets alternate.
  // rdy_mode: 0 always ready, 1 random, 2 stall three cycles at index 2.
  task automatic run_window(input int wl, input int mode, input int rdy_mode, input bit poke);
    int idx;
    int stall;
    bit r;
    logic [W-1:0] v;
    smp.delete();
    for (int i = 0; i <= wl; i++) begin
      case (mode)
        1: v = 4'b0100 | W'(i % 2);
        2: v = 4'b1000 | W'((i % 2) << 1);
        3: v = (i % 2 == 0) ? 4'b1111 : 4'b0000;
        default: v = W'($urandom);
      endcase
      smp.push_back(v);
    end
    compute_model();
    start = 1'b1; win_len = 16'(wl); probe = smp[0];
    expect_idle();
    @(posedge clk); #1;
    start = 1'b0;
    e_total_en = 1'b0;
    for (int k = 0; k < wl; k++) begin
      probe = smp[k+1];
      win_len = 16'($urandom);
      start = (poke && k == 1);
      e_busy = 1'b1; e_valid = 1'b0; e_done = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    idx = 0;
    stall = 0;
    e_total_en = 1'b1;
    e_total = m_total;
    forever begin
      e_busy = 1'b1; e_valid = 1'b1; e_done = 1'b0;
      e_idx = idx; e_cnt = m_cnt[idx]; e_sat = m_sat[idx];
      probe = W'($urandom);
      obs_cnt[idx] = int'(out_count);
      obs_sat[idx] = int'(out_sat);
`ifdef TAC_TOTAL_EN
      obs_total = int'(total_count);
`endif
      case (rdy_mode)
        1: r = 1'($urandom_range(0, 1));
        2: begin
          r = !(idx == 2 && stall < 3);
          if (!r) stall++;
        end
        default: r = 1'b1;
      endcase
      out_ready = r;
      @(posedge clk); #1;
      if (r) begin
        if (idx == W - 1) break;
        idx++;
      end
    end
    out_ready = 1'b0;
    n_windows++;
    e_busy = 1'b0; e_valid = 1'b0; e_done = 1'b1;
    start = 1'b1; win_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    expect_idle();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_out_count"}, out_count, 0);
    chk({tag, "_out_sat"}, out_sat, 0);
`ifdef TAC_TOTAL_EN
    chk({tag, "_total"}, total_count, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, wl;
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_idle();
    e_total_en = 1'b0;
    check_en = 1'b1;

    run_window(10, 1, 0, 1'b0);
    chk("t1_cnt0", obs_cnt[0], 10);
    chk("t1_cnt1", obs_cnt[1], 0);
    chk("t1_cnt3", obs_cnt[3], 0);
    chk("t1_sat0", obs_sat[0], 0);

    run_window(20, 2, 1, 1'b0);
    chk("t2_cnt1", obs_cnt[1], 15);
    chk("t2_sat1", obs_sat[1], 1);
    chk("t2_sat0", obs_sat[0], 0);

    b0 = busy_cyc;
    run_window(0, 0, 0, 1'b0);
    chk("t3_busy_cycles", busy_cyc - b0, 4);
    chk("t3_cnt2", obs_cnt[2], 0);

    run_window(8, 0, 2, 1'b0);
    run_window(12, 0, 1, 1'b1);

    start = 1'b1; win_len = 16'd10; probe = W'($urandom);
    expect_idle();
    @(posedge clk); #1;
    start = 1'b0;
    e_total_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      probe = W'($urandom);
      e_busy = 1'b1; e_valid = 1'b0; e_done = 1'b0;
      @(posedge clk); #1;
    end
    check_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_idle();
    check_en = 1'b1;
    @(posedge clk); #1;
    run_window(4, 3, 0, 1'b0);
    chk("t6_cnt0", obs_cnt[0], 4);
    chk("t6_cnt3", obs_cnt[3], 4);
`ifdef TAC_TOTAL_EN
    chk("t6_total", obs_total, 16);
`endif

    for (int t = 0; t < 12; t++) begin
      wl = $urandom_range(0, 25);
      run_window(wl, 0, 1, (wl >= 3) && ($urandom_range(0, 1) == 1));
    end

    check_en = 1'b0;
    chk("done_pulses", done_cnt, n_windows);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
